// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (A - B, LSB first) framed by a start/busy/done handshake.
// Optional signed-overflow flag is built only when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-2:0] r_res;
  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;

  logic             w_half1Diff;
  logic             w_d;
  logic             w_brNext;
  logic             w_last;
  logic [WIDTH-1:0] w_resFull;

  // Two cascaded half subtractors: (sa - sb), then (that - borrow-in).
  assign w_half1Diff = r_sa[0] ^ r_sb[0];
  assign w_d         = w_half1Diff ^ r_br;
  assign w_brNext    = (~r_sa[0] & r_sb[0]) | (~w_half1Diff & r_br);
  assign w_last      = (r_cnt == CW'(WIDTH - 1));
  // The partial result holds WIDTH-1 bits; the current bit completes it.
  assign w_resFull   = {w_d, r_res};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_stateNext = S_SHIFT;
      S_SHIFT: if (w_last) w_stateNext = S_DONE;
      S_DONE:  w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_res    <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sa  <= a;
            r_sb  <= b;
            r_br  <= 1'b0;
            r_cnt <= '0;
          end
        end
        S_SHIFT: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_br  <= w_brNext;
          r_res <= w_resFull[WIDTH-1:1];
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_diff   <= w_resFull;
            r_borrow <= w_brNext;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic r_aMsb;
  logic r_bMsb;
  logic r_ovf;

  // Operand signs are kept because the shift registers lose them during the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aMsb <= 1'b0;
      r_bMsb <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_aMsb <= a[WIDTH-1];
        r_bMsb <= b[WIDTH-1];
      end
      if (r_state == S_SHIFT && w_last) begin
        r_ovf <= (r_aMsb != r_bMsb) && (w_d != r_aMsb);
      end
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign diff       = r_diff;
  assign borrow_out = r_borrow;

endmodule
